// File: rtl/spi_pkg.sv
// Shared types and opcode table for the SPI frame decoder.
package spi_pkg;

  localparam int MAX_PAYLOAD_DEF = 4;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_kind_t;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BAD_OPCODE = 3'd1,
    ERR_BAD_LEN    = 3'd2,
    ERR_BAD_CKSUM  = 3'd3,
    ERR_ABORT      = 3'd4,
    ERR_OVERRUN    = 3'd5
  } err_code_t;

  // {legal, payload length} for a given opcode byte
  function automatic logic [8:0] expected_len(input logic [7:0] opcode);
    case (opcode)
      OP_NOP:   return {1'b1, 8'd0};
      OP_WRITE: return {1'b1, 8'd2};
      OP_READ:  return {1'b1, 8'd1};
      OP_CLEAR: return {1'b1, 8'd0};
      default:  return {1'b0, 8'd0};
    endcase
  endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// Byte-stream input and decoded-command output bundle of the frame decoder.
interface spi_frame_decoder_if;
  logic       cs_active_i;
  logic       byte_valid_i;
  logic [7:0] byte_i;
  logic       cmd_ready_i;
  logic       cmd_valid_o;
  logic [1:0] cmd_kind_o;
  logic [7:0] cmd_addr_o;
  logic [7:0] cmd_data_o;
  logic       err_o;
  logic [2:0] err_code_o;

  modport slave (
    input  cs_active_i, byte_valid_i, byte_i, cmd_ready_i,
    output cmd_valid_o, cmd_kind_o, cmd_addr_o, cmd_data_o, err_o, err_code_o
  );

  modport master (
    output cs_active_i, byte_valid_i, byte_i, cmd_ready_i,
    input  cmd_valid_o, cmd_kind_o, cmd_addr_o, cmd_data_o, err_o, err_code_o
  );
endinterface

// File: rtl/spi_frame_decoder_holder.sv
// Valid/ready output register for decoded commands; flags a new command
// arriving while the previous one is still unaccepted.
module spi_cmd_holder
  import spi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       new_valid,
  input  cmd_kind_t  new_kind,
  input  logic [7:0] new_addr,
  input  logic [7:0] new_data,
  input  logic       ready,
  output logic       valid,
  output cmd_kind_t  kind,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       overrun
);

  // a transfer in the same cycle frees the slot, so the new command wins
  assign overrun = new_valid & valid & ~ready;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= 1'b0;
      kind  <= CMD_NOP;
      addr  <= 8'h00;
      data  <= 8'h00;
    end else if (new_valid && !overrun) begin
      valid <= 1'b1;
      kind  <= new_kind;
      addr  <= new_addr;
      data  <= new_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
      kind  <= CMD_NOP;
      addr  <= 8'h00;
      data  <= 8'h00;
    end
  end

endmodule

// File: rtl/spi_frame_decoder.sv
// Parses [opcode][len][payload][cksum] frames from the SPI receiver byte stream.
//   state     | meaning
//   S_IDLE    | waiting for opcode byte
//   S_LEN     | opcode latched, waiting for length byte
//   S_PAYLOAD | collecting payload bytes
//   S_CKSUM   | waiting for checksum byte
//   S_DROP    | bad frame, discard bytes until chip-select drops
module spi_frame_decoder
  import spi_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  spi_frame_decoder_if.slave bus
);

  localparam int IDX_W  = $clog2(MAX_PAYLOAD + 1);
  localparam int BUF_AW = $clog2(MAX_PAYLOAD);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [7:0]       MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CKSUM, S_DROP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [7:0]       cksum_q, cksum_d;
  logic [IDX_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [7:0]       buf_q [MAX_PAYLOAD];
  logic             buf_we;
  logic             frame_good, err_det, overrun;
  err_code_t        err_sel;
  logic [8:0]       exp_len;
  cmd_kind_t        new_kind;
  logic [7:0]       new_addr, new_data;
  logic             byte_ok;

  // a byte arriving together with chip-select falling is discarded
  assign byte_ok = bus.cs_active_i & bus.byte_valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      opcode_q <= 8'h00;
      cksum_q  <= 8'h00;
      len_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cksum_q  <= cksum_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < MAX_PAYLOAD; i++) buf_q[i] <= 8'h00;
    end else if (buf_we) begin
      buf_q[idx_q[BUF_AW-1:0]] <= bus.byte_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    cksum_d    = cksum_q;
    len_d      = len_q;
    idx_d      = idx_q;
    buf_we     = 1'b0;
    frame_good = 1'b0;
    err_det    = 1'b0;
    err_sel    = ERR_NONE;
    exp_len    = expected_len(opcode_q);
    case (state_q)
      S_IDLE: begin
        if (byte_ok) begin
          opcode_d = bus.byte_i;
          cksum_d  = bus.byte_i;
          state_d  = S_LEN;
        end
      end
      S_LEN: begin
        if (!bus.cs_active_i) begin
          err_det = 1'b1;
          err_sel = ERR_ABORT;
          state_d = S_IDLE;
        end else if (byte_ok) begin
          if (!exp_len[8]) begin
            err_det = 1'b1;
            err_sel = ERR_BAD_OPCODE;
            state_d = S_DROP;
          end else if (bus.byte_i != exp_len[7:0] || bus.byte_i > MAX_LEN) begin
            err_det = 1'b1;
            err_sel = ERR_BAD_LEN;
            state_d = S_DROP;
          end else begin
            cksum_d = cksum_q ^ bus.byte_i;
            len_d   = bus.byte_i[IDX_W-1:0];
            idx_d   = '0;
            state_d = (bus.byte_i == 8'h00) ? S_CKSUM : S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (!bus.cs_active_i) begin
          err_det = 1'b1;
          err_sel = ERR_ABORT;
          state_d = S_IDLE;
        end else if (byte_ok) begin
          buf_we  = 1'b1;
          cksum_d = cksum_q ^ bus.byte_i;
          idx_d   = idx_q + IDX_ONE;
          if (idx_q == len_q - IDX_ONE) state_d = S_CKSUM;
        end
      end
      S_CKSUM: begin
        if (!bus.cs_active_i) begin
          err_det = 1'b1;
          err_sel = ERR_ABORT;
          state_d = S_IDLE;
        end else if (byte_ok) begin
          if (bus.byte_i == cksum_q) begin
            frame_good = 1'b1;
          end else begin
            err_det = 1'b1;
            err_sel = ERR_BAD_CKSUM;
          end
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (!bus.cs_active_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign new_kind = cmd_kind_t'(opcode_q[1:0]);
  assign new_addr = (new_kind == CMD_WRITE || new_kind == CMD_READ) ? buf_q[0] : 8'h00;
  assign new_data = (new_kind == CMD_WRITE) ? buf_q[1] : 8'h00;

  spi_cmd_holder u_holder (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .new_valid (frame_good),
    .new_kind  (new_kind),
    .new_addr  (new_addr),
    .new_data  (new_data),
    .ready     (bus.cmd_ready_i),
    .valid     (bus.cmd_valid_o),
    .kind      (bus.cmd_kind_o),
    .addr      (bus.cmd_addr_o),
    .data      (bus.cmd_data_o),
    .overrun   (overrun)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.err_o      <= 1'b0;
      bus.err_code_o <= ERR_NONE;
    end else begin
      bus.err_o <= err_det | overrun;
      if (overrun)      bus.err_code_o <= ERR_OVERRUN;
      else if (err_det) bus.err_code_o <= err_sel;
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed and randomized frame tests for spi_frame_decoder against a frame-level model.
module tb_spi_frame_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   err_pulses = 0;

  spi_frame_decoder_if bus();

  spi_frame_decoder dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (bus.err_o === 1'b1) err_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic       good;
    logic [2:0] err;
    logic [1:0] kind;
    logic [7:0] addr;
    logic [7:0] data;
  } outcome_t;

  // frame-level reference: what a complete frame must produce
  function automatic outcome_t model_frame(input logic [7:0] f[$]);
    outcome_t   o;
    int         n;
    logic [7:0] c;
    o = '0;
    if (f[0] > 8'd3) begin
      o.err = 3'd1;
      return o;
    end
    n = (f[0] == 8'd1) ? 2 : (f[0] == 8'd2) ? 1 : 0;
    if (int'(f[1]) != n) begin
      o.err = 3'd2;
      return o;
    end
    c = 8'h00;
    for (int i = 0; i < n + 2; i++) c ^= f[i];
    if (f[n+2] != c) begin
      o.err = 3'd3;
      return o;
    end
    o.good = 1'b1;
    o.kind = f[0][1:0];
    o.addr = (n >= 1) ? f[2] : 8'h00;
    o.data = (n == 2) ? f[3] : 8'h00;
    return o;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int max_gap);
    foreach (f[i]) begin
      send_byte(f[i]);
      if (max_gap > 0 && i != f.size() - 1) tick(int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic accept();
    bus.cmd_ready_i = 1'b1;
    tick(1);
    bus.cmd_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o, bus.err_o, bus.err_code_o} !== 23'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0",
               {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o, bus.err_o, bus.err_code_o});
    end
  endtask

  task automatic test_write();
    logic [18:0] want;
    bus.cs_active_i = 1'b1;
    send_frame('{8'h01, 8'h02, 8'h10, 8'hAB}, 0);
    vectors++;
    if (bus.cmd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL write_early_valid got %b want 0", bus.cmd_valid_o);
    end
    send_byte(8'hB8);
    want = {1'b1, 2'd1, 8'h10, 8'hAB};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o} !== want) begin
        miscompares++;
        $display("FAIL write_cmd_hold%0d got %h want %h", i,
                 {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o}, want);
      end
      tick(1);
    end
    accept();
    vectors++;
    if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o} !== 19'h0) begin
      miscompares++;
      $display("FAIL write_cleared got %h want 0",
               {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o});
    end
    bus.cs_active_i = 1'b0;
    tick(1);
  endtask

  task automatic test_bad_cksum();
    int p = err_pulses;
    bus.cs_active_i = 1'b1;
    send_frame('{8'h02, 8'h01, 8'h20, 8'h00}, 0);
    vectors++;
    if ({bus.err_o, bus.err_code_o, bus.cmd_valid_o} !== {1'b1, 3'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL cksum_err got err=%b code=%0d valid=%b want 1 3 0", bus.err_o, bus.err_code_o, bus.cmd_valid_o);
    end
    tick(1);
    vectors++;
    if ({bus.err_o, bus.err_code_o} !== {1'b0, 3'd3} || err_pulses - p != 1) begin
      miscompares++;
      $display("FAIL cksum_pulse got err=%b code=%0d pulses=%0d want 0 3 1", bus.err_o, bus.err_code_o, err_pulses - p);
    end
    bus.cs_active_i = 1'b0;
    tick(1);
  endtask

  task automatic test_bad_opcode();
    int p = err_pulses;
    bus.cs_active_i = 1'b1;
    send_frame('{8'h07, 8'h11, 8'h22, 8'h33, 8'h44}, 1);
    bus.cs_active_i = 1'b0;
    tick(2);
    vectors++;
    if (bus.err_code_o !== 3'd1 || err_pulses - p != 1) begin
      miscompares++;
      $display("FAIL opcode_err got code=%0d pulses=%0d want 1 1", bus.err_code_o, err_pulses - p);
    end
    bus.cs_active_i = 1'b1;
    send_frame('{8'h03, 8'h00, 8'h03}, 0);
    vectors++;
    if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o} !== {1'b1, 2'd3, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL clear_after_drop got %h want %h",
               {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o}, {1'b1, 2'd3, 16'h0});
    end
    accept();
    bus.cs_active_i = 1'b0;
    tick(1);
  endtask

  task automatic test_abort();
    int p = err_pulses;
    bus.cs_active_i = 1'b1;
    send_frame('{8'h01, 8'h02, 8'h10}, 0);
    bus.cs_active_i = 1'b0;
    tick(1);
    vectors++;
    if (bus.err_code_o !== 3'd4 || err_pulses - p != 1 || bus.cmd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_err got code=%0d pulses=%0d valid=%b want 4 1 0", bus.err_code_o, err_pulses - p, bus.cmd_valid_o);
    end
    bus.cs_active_i = 1'b1;
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    vectors++;
    if ({bus.cmd_valid_o, bus.cmd_kind_o} !== {1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL nop_after_abort got valid=%b kind=%0d want 1 0", bus.cmd_valid_o, bus.cmd_kind_o);
    end
    accept();
    bus.cs_active_i = 1'b0;
    tick(1);
  endtask

  task automatic test_overrun();
    int p = err_pulses;
    bus.cs_active_i = 1'b1;
    send_frame('{8'h02, 8'h01, 8'h05, 8'h06}, 0);
    send_frame('{8'h02, 8'h01, 8'h33, 8'h30}, 0);
    vectors++;
    if (bus.err_code_o !== 3'd5 || err_pulses - p != 1) begin
      miscompares++;
      $display("FAIL overrun_err got code=%0d pulses=%0d want 5 1", bus.err_code_o, err_pulses - p);
    end
    vectors++;
    if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o} !== {1'b1, 2'd2, 8'h05}) begin
      miscompares++;
      $display("FAIL overrun_keep got %h want %h", {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o}, {1'b1, 2'd2, 8'h05});
    end
    accept();
    vectors++;
    if (bus.cmd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_drained got valid=%b want 0", bus.cmd_valid_o);
    end
    bus.cs_active_i = 1'b0;
    tick(1);
  endtask

  task automatic test_back_to_back();
    int p = err_pulses;
    bus.cs_active_i = 1'b1;
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    send_frame('{8'h01, 8'h02, 8'h44, 8'h55}, 0);
    bus.cmd_ready_i = 1'b1;
    send_byte(8'h12);
    bus.cmd_ready_i = 1'b0;
    vectors++;
    if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o} !== {1'b1, 2'd1, 8'h44, 8'h55}
        || err_pulses != p) begin
      miscompares++;
      $display("FAIL new_wins got %h pulses=%0d want %h 0",
               {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o}, err_pulses - p,
               {1'b1, 2'd1, 8'h44, 8'h55});
    end
    accept();
    bus.cs_active_i = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid();
    bus.cs_active_i = 1'b1;
    send_frame('{8'h02, 8'h01, 8'h20, 8'h00}, 0);
    send_frame('{8'h03, 8'h00, 8'h03}, 0);
    send_frame('{8'h01, 8'h02, 8'h10}, 0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o, bus.err_o, bus.err_code_o} !== 23'h0) begin
      miscompares++;
      $display("FAIL async_reset got %h want 0",
               {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o, bus.err_o, bus.err_code_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    send_frame('{8'h01, 8'h02, 8'h10, 8'hAB, 8'hB8}, 0);
    vectors++;
    if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o} !== {1'b1, 2'd1, 8'h10, 8'hAB}) begin
      miscompares++;
      $display("FAIL post_reset_frame got %h want %h",
               {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o}, {1'b1, 2'd1, 8'h10, 8'hAB});
    end
    accept();
    bus.cs_active_i = 1'b0;
    tick(1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [7:0] f[$];
      logic [7:0] op, ln, c;
      int         kind, plen, p;
      outcome_t   exp;
      kind = int'($urandom_range(3, 0));
      f = {};
      if (kind == 2) begin
        op = 8'($urandom_range(255, 4));
        f.push_back(op);
        f.push_back(8'($urandom));
        repeat ($urandom_range(3, 0)) f.push_back(8'($urandom));
      end else begin
        op = 8'($urandom_range(3, 0));
        plen = (op == 8'd1) ? 2 : (op == 8'd2) ? 1 : 0;
        f.push_back(op);
        if (kind == 3) begin
          do ln = 8'($urandom_range(9, 0)); while (int'(ln) == plen);
          f.push_back(ln);
          repeat ($urandom_range(3, 0)) f.push_back(8'($urandom));
        end else begin
          f.push_back(8'(plen));
          repeat (plen) f.push_back(8'($urandom));
          c = 8'h00;
          foreach (f[i]) c ^= f[i];
          if (kind == 1) c ^= 8'($urandom_range(255, 1));
          f.push_back(c);
        end
      end
      exp = model_frame(f);
      p = err_pulses;
      bus.cs_active_i = 1'b1;
      send_frame(f, 2);
      if (!exp.good) tick(1);
      vectors++;
      if (exp.good) begin
        if ({bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o} !== {1'b1, exp.kind, exp.addr, exp.data}
            || err_pulses != p) begin
          miscompares++;
          $display("FAIL rand_good%0d got %h pulses=%0d want %h 0", n,
                   {bus.cmd_valid_o, bus.cmd_kind_o, bus.cmd_addr_o, bus.cmd_data_o}, err_pulses - p,
                   {1'b1, exp.kind, exp.addr, exp.data});
        end
        accept();
      end else begin
        if (bus.err_code_o !== exp.err || err_pulses - p != 1 || bus.cmd_valid_o !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_err%0d got code=%0d pulses=%0d valid=%b want %0d 1 0", n,
                   bus.err_code_o, err_pulses - p, bus.cmd_valid_o, exp.err);
        end
      end
      bus.cs_active_i = 1'b0;
      tick(int'($urandom_range(2, 1)));
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.cs_active_i  = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    bus.cmd_ready_i  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    test_reset();
    test_write();
    test_bad_cksum();
    test_bad_opcode();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
